// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between the IFU and LSU.
// One request is in flight at a time: accept, drive the port, capture, then respond.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [3:0]            lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,

    output logic                  mem_en,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    state_t state;
    state_t state_next;
    owner_t last_grant;
    owner_t owner;
    logic   wen_q;
    logic   grant_ifu;
    logic   grant_lsu;

    // Grant and next-state decode; ready is the grant itself, so it only rises in IDLE.
    always_comb begin
        state_next = state;
        grant_ifu  = 1'b0;
        grant_lsu  = 1'b0;
        case (state)
            IDLE: begin
                if (ifu_req_valid && lsu_req_valid) begin
                    if (last_grant == OWN_IFU) begin
                        grant_lsu = 1'b1;
                    end else begin
                        grant_ifu = 1'b1;
                    end
                end else if (ifu_req_valid) begin
                    grant_ifu = 1'b1;
                end else if (lsu_req_valid) begin
                    grant_lsu = 1'b1;
                end
                if (grant_ifu || grant_lsu) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accept latches the request straight into the memory-port registers, so the
    // port is live in the ACCESS cycle and later input changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant     <= OWN_IFU;
            owner          <= OWN_IFU;
            wen_q          <= 1'b0;
            mem_en         <= 1'b0;
            mem_wen        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_rdata      <= '0;
        end else begin
            mem_en         <= 1'b0;
            mem_wen        <= 1'b0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ifu) begin
                        owner      <= OWN_IFU;
                        last_grant <= OWN_IFU;
                        wen_q      <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_wen    <= 1'b0;
                        mem_addr   <= ifu_addr[ADDR_WIDTH-1:2];
                        mem_wdata  <= '0;
                        mem_wmask  <= '0;
                    end else if (grant_lsu) begin
                        owner      <= OWN_LSU;
                        last_grant <= OWN_LSU;
                        wen_q      <= lsu_wen;
                        mem_en     <= 1'b1;
                        mem_wen    <= lsu_wen;
                        mem_addr   <= lsu_addr[ADDR_WIDTH-1:2];
                        mem_wdata  <= lsu_wdata;
                        mem_wmask  <= lsu_wmask;
                    end
                end
                CAPTURE: begin
                    // Memory data is valid now, one cycle after the strobe.
                    if (owner == OWN_LSU) begin
                        lsu_rdata      <= wen_q ? '0 : mem_rdata;
                        lsu_resp_valid <= 1'b1;
                    end else begin
                        ifu_rdata      <= mem_rdata;
                        ifu_resp_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory model on the port.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [7:0]  ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [7:0]  lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_en;
    logic        mem_wen;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];

    int passed = 0;
    int total  = 0;

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_en         (mem_en),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read memory: data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wmask[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 + i;
        mem[0] = 32'h1111_0000;
        mem[1] = 32'h0000_0101;
        mem[2] = 32'hDEAD_BEEF;
        mem[3] = 32'hCAFE_F00D;
        mem[4] = 32'hA5A5_0004;
        mem[8] = 32'h8888_8888;
        mem_rdata     = '0;
        rst           = 1'b1;
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        tick();
        tick();
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_ifu_resp", {31'b0, ifu_resp_valid}, 32'd0);
        chk("rst_rdata", ifu_rdata | lsu_rdata, 32'd0);
        chk("rst_mem_addr", {26'b0, mem_addr}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_no_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 32'd0);

        // IFU read 0x08
        ifu_req_valid = 1'b1;
        ifu_addr      = 8'h08;
        #1;
        chk("s1_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b10);
        tick();
        ifu_req_valid = 1'b0;
        chk("s1_mem_en", {31'b0, mem_en}, 32'd1);
        chk("s1_mem_wen", {31'b0, mem_wen}, 32'd0);
        chk("s1_mem_addr", {26'b0, mem_addr}, 32'd2);
        tick();
        chk("s1_en_one_cycle", {31'b0, mem_en}, 32'd0);
        chk("s1_resp_early", {31'b0, ifu_resp_valid}, 32'd0);
        tick();
        chk("s1_resp", {30'b0, ifu_resp_valid, lsu_resp_valid}, 32'b10);
        chk("s1_rdata", ifu_rdata, 32'hDEAD_BEEF);
        tick();
        chk("s1_resp_pulse", {31'b0, ifu_resp_valid}, 32'd0);
        chk("s1_rdata_hold", ifu_rdata, 32'hDEAD_BEEF);

        // Tie from reset: LSU first, then strict alternation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr      = 8'h00;
        lsu_req_valid = 1'b1;
        lsu_addr      = 8'h10;
        lsu_wen       = 1'b0;
        #1;
        chk("s2_tie1_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b01);
        tick();
        chk("s2_tie1_addr", {26'b0, mem_addr}, 32'd4);
        chk("s2_busy_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b00);
        tick();
        tick();
        chk("s2_lsu_resp", {30'b0, ifu_resp_valid, lsu_resp_valid}, 32'b01);
        chk("s2_lsu_rdata", lsu_rdata, 32'hA5A5_0004);
        tick();
        chk("s2_tie2_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b10);
        tick();
        chk("s2_tie2_addr", {26'b0, mem_addr}, 32'd0);
        tick();
        tick();
        chk("s2_ifu_resp", {30'b0, ifu_resp_valid, lsu_resp_valid}, 32'b10);
        chk("s2_ifu_rdata", ifu_rdata, 32'h1111_0000);
        tick();
        chk("s2_tie3_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b01);
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        chk("s2_tie3_addr", {26'b0, mem_addr}, 32'd4);
        tick();
        tick();
        tick();

        // LSU masked write 0x0C
        lsu_req_valid = 1'b1;
        lsu_addr      = 8'h0C;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'h1234_5678;
        lsu_wmask     = 4'b0011;
        #1;
        chk("s3_ready", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b01);
        tick();
        lsu_req_valid = 1'b0;
        chk("s3_en_wen", {30'b0, mem_en, mem_wen}, 32'b11);
        chk("s3_addr", {26'b0, mem_addr}, 32'd3);
        chk("s3_wmask", {28'b0, mem_wmask}, 32'b0011);
        chk("s3_wdata", mem_wdata, 32'h1234_5678);
        tick();
        tick();
        chk("s3_ack", {30'b0, ifu_resp_valid, lsu_resp_valid}, 32'b01);
        chk("s3_ack_rdata", lsu_rdata, 32'd0);
        tick();

        // IFU reads the written word back
        ifu_req_valid = 1'b1;
        ifu_addr      = 8'h0C;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        tick();
        chk("s3_readback", ifu_rdata, 32'hCAFE_5678);
        tick();

        // Unaligned IFU 0x0B
        ifu_req_valid = 1'b1;
        ifu_addr      = 8'h0B;
        tick();
        ifu_req_valid = 1'b0;
        chk("s4_addr", {26'b0, mem_addr}, 32'd2);
        tick();
        tick();
        chk("s4_resp", {31'b0, ifu_resp_valid}, 32'd1);
        chk("s4_rdata", ifu_rdata, 32'hDEAD_BEEF);
        tick();

        // Reset during CAPTURE
        ifu_req_valid = 1'b1;
        ifu_addr      = 8'h04;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("s5_rst_outputs", {31'b0, mem_en | ifu_resp_valid | lsu_resp_valid}, 32'd0);
        chk("s5_rst_rdata", ifu_rdata, 32'd0);
        tick();
        rst = 1'b0;
        chk("s5_no_resp1", {30'b0, ifu_resp_valid, lsu_resp_valid}, 32'b00);
        tick();
        chk("s5_no_resp2", {30'b0, ifu_resp_valid, lsu_resp_valid}, 32'b00);
        lsu_req_valid = 1'b1;
        lsu_addr      = 8'h10;
        lsu_wen       = 1'b0;
        #1;
        chk("s5_ready_after", {30'b0, ifu_req_ready, lsu_req_ready}, 32'b01);
        tick();
        lsu_req_valid = 1'b0;
        tick();
        tick();
        chk("s5_resp_after", {30'b0, ifu_resp_valid, lsu_resp_valid}, 32'b01);
        chk("s5_rdata_after", lsu_rdata, 32'hA5A5_0004);
        tick();

        // Address changes after accept do not reach the in-flight access
        ifu_req_valid = 1'b1;
        ifu_addr      = 8'h04;
        tick();
        ifu_addr      = 8'h20;
        ifu_req_valid = 1'b0;
        chk("s6_addr", {26'b0, mem_addr}, 32'd1);
        tick();
        chk("s6_addr_hold", {26'b0, mem_addr}, 32'd1);
        tick();
        chk("s6_rdata", ifu_rdata, 32'h0000_0101);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
